// File: rtl/filter_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : filter_stream_gen_if
//  Purpose  : Bus bundle for filter_stream_gen. It groups the weight-RAM read
//             port and the tap stream handshake.
//  Signals  : mem_rd/mem_addr  -> RAM read strobe and address (master drives)
//             mem_rdata        <- RAM read data, valid 1 cycle after mem_rd
//             fil_out/fil_valid/fil_last -> tap stream (master drives)
//             fil_ready        <- consumer accepts the current tap
//  Modports : master = filter_stream_gen side, slave = RAM + MAC array side
//  Revision : 1.0  initial release
// ============================================================================
interface filter_stream_gen_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] fil_out;
  logic          fil_valid;
  logic          fil_ready;
  logic          fil_last;

  modport master (
    output mem_rd, mem_addr, fil_out, fil_valid, fil_last,
    input  mem_rdata, fil_ready
  );

  modport slave (
    input  mem_rd, mem_addr, fil_out, fil_valid, fil_last,
    output mem_rdata, fil_ready
  );
endinterface
`default_nettype wire

// File: rtl/filter_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : filter_stream_gen
//  Purpose  : Loads one KxK kernel from a synchronous weight RAM into a local
//             tap buffer, then streams the taps in raster order repeat_cnt
//             times over a valid/ready handshake (one pass per output pixel).
//  Ports    : clk, rst (sync, active low)
//             start/base_addr/repeat_cnt/flip : job request, sampled in IDLE
//             bus (filter_stream_gen_if.master) : RAM read port + tap stream
//             busy, done (1-cycle pulse), state (debug FSM code)
//  Config   : FILTER_STREAM_FLIP_EN defined -> flip=1 emits taps in 180-degree
//             rotated order. Undefined -> flip is ignored, raster order only.
//  Revision : 1.0  initial release
// ============================================================================
module filter_stream_gen #(
  parameter int DW  = 8,
  parameter int K   = 3,
  parameter int AW  = 8,
  parameter int RCW = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           start,
  input  wire logic [AW-1:0]  base_addr,
  input  wire logic [RCW-1:0] repeat_cnt,
  input  wire logic           flip,
  filter_stream_gen_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  localparam int N  = K * K;
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(N + 1);

  localparam logic [TW-1:0] c_last_tap = TW'(N - 1);
  localparam logic [LW-1:0] c_load_end = LW'(N);
  localparam logic [LW-1:0] c_load_rd_last = LW'(N - 1);

`ifdef FILTER_STREAM_FLIP_EN
  localparam logic c_flip_en = 1'b1;
`else
  localparam logic c_flip_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_buf [N];
  logic [TW-1:0]   r_tap;
  logic [RCW-1:0]  r_pass;
  logic [RCW-1:0]  r_rep;
  logic            r_flip;
  logic [LW-1:0]   r_load_cnt;
  logic            r_mem_rd;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_fil_out;
  logic            r_fil_valid;
  logic            r_fil_last;
  logic            r_busy;
  logic            r_done;

  // Map a raster tap index to the buffer slot actually emitted.
  function automatic logic [TW-1:0] f_emit(input logic [TW-1:0] t, input logic fl);
    return fl ? (c_last_tap - t) : t;
  endfunction

  logic          w_flip;
  logic [TW-1:0] w_wr_idx;
  logic [TW-1:0] w_e0;
  logic [DW-1:0] w_first;
  logic [TW-1:0] w_tap_nx;

  assign w_flip   = r_flip & c_flip_en;
  assign w_wr_idx = TW'(r_load_cnt - LW'(1));
  assign w_e0     = f_emit('0, w_flip);
  // The last buffer slot is written on the same edge that enters STREAM, so
  // the first emitted tap is forwarded straight from the RAM when it lands there.
  assign w_first  = (w_e0 == c_last_tap) ? bus.mem_rdata : r_buf[w_e0];
  assign w_tap_nx = (r_tap == c_last_tap) ? '0 : r_tap + TW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_tap       <= '0;
      r_pass      <= '0;
      r_rep       <= '0;
      r_flip      <= 1'b0;
      r_load_cnt  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_fil_out   <= '0;
      r_fil_valid <= 1'b0;
      r_fil_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rep      <= repeat_cnt;
            r_flip     <= flip;
            r_load_cnt <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= base_addr;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Read data lags the strobe by one cycle, hence the index offset.
          if (r_load_cnt != '0) r_buf[w_wr_idx] <= bus.mem_rdata;
          if (r_load_cnt == c_load_end) begin
            r_mem_addr <= '0;
            r_tap      <= '0;
            r_pass     <= '0;
            if (r_rep != '0) begin
              r_fil_valid <= 1'b1;
              r_fil_out   <= w_first;
              r_fil_last  <= (N == 1);
              r_state     <= S_STREAM;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_load_cnt <= r_load_cnt + LW'(1);
            r_mem_rd   <= (r_load_cnt != c_load_rd_last);
            r_mem_addr <= (r_load_cnt == c_load_rd_last) ? '0 : r_mem_addr + AW'(1);
          end
        end

        S_STREAM: begin
          if (bus.fil_ready) begin
            if (r_tap == c_last_tap && r_pass == r_rep - RCW'(1)) begin
              r_fil_valid <= 1'b0;
              r_fil_out   <= '0;
              r_fil_last  <= 1'b0;
              r_tap       <= '0;
              r_pass      <= '0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              if (r_tap == c_last_tap) r_pass <= r_pass + RCW'(1);
              r_tap      <= w_tap_nx;
              r_fil_out  <= r_buf[f_emit(w_tap_nx, w_flip)];
              r_fil_last <= (w_tap_nx == c_last_tap);
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.fil_out   = r_fil_out;
  assign bus.fil_valid = r_fil_valid;
  assign bus.fil_last  = r_fil_last;
  assign busy          = r_busy;
  assign done          = r_done;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_filter_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_stream_gen
//  Purpose  : Self-checking bench for filter_stream_gen (K=3, DW=8, AW=8).
//             Expected taps and RAM addresses are queued when a job is issued;
//             negedge monitors pop and compare as the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_filter_stream_gen;

  localparam int DW = 8, K = 3, AW = 8, RCW = 16;
  localparam int N  = K * K;
`ifdef FILTER_STREAM_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } tap_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [RCW-1:0] repeat_cnt;
  logic           flip;
  logic           busy, done;
  logic [1:0]     state;

  filter_stream_gen_if #(.DW(DW), .AW(AW)) bus ();

  filter_stream_gen #(.DW(DW), .K(K), .AW(AW), .RCW(RCW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .repeat_cnt(repeat_cnt), .flip(flip), .bus(bus),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Weight RAM model: synchronous read, one cycle latency.
  logic [DW-1:0] ram [256];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

  tap_t          tapq[$];
  logic [AW-1:0] addrq[$];

  // Consumer ready pattern: 0 = always, 1 = toggle, 2 = random.
  int ready_mode = 0;
  initial begin
    bus.fil_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.fil_ready = 1'b1;
        1:       bus.fil_ready = ~bus.fil_ready;
        default: bus.fil_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: accepted taps, stall stability, RAM read addresses.
  logic          stalled = 1'b0;
  logic [DW-1:0] held_out;
  logic          held_last;
  always @(negedge clk) begin
    if (!rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && bus.fil_valid) begin
        chk("stall_hold_out", 32'(bus.fil_out), 32'(held_out));
        chk("stall_hold_last", 32'(bus.fil_last), 32'(held_last));
      end
      if (bus.fil_valid && bus.fil_ready) begin
        if (tapq.size() == 0) chk("unexpected_tap", 32'(bus.fil_out), 32'hDEAD);
        else begin
          tap_t e;
          e = tapq.pop_front();
          chk("tap_data", 32'(bus.fil_out), 32'(e.d));
          chk("tap_last", 32'(bus.fil_last), 32'(e.l));
        end
      end
      stalled   <= bus.fil_valid && !bus.fil_ready;
      held_out  <= bus.fil_out;
      held_last <= bus.fil_last;
      if (bus.mem_rd) begin
        if (addrq.size() == 0) chk("unexpected_read", 32'(bus.mem_addr), 32'hDEAD);
        else chk("mem_addr", 32'(bus.mem_addr), 32'(addrq.pop_front()));
      end
    end
  end

  // Reference model: a job reads N consecutive addresses and emits the kernel
  // rep times, each pass in raster (or rotated) order, last flag on slot N-1.
  task automatic expect_job(input int base, input int rep, input bit fl);
    tap_t e;
    for (int i = 0; i < N; i++) addrq.push_back(AW'((base + i) % 256));
    for (int p = 0; p < rep; p++)
      for (int t = 0; t < N; t++) begin
        int idx;
        idx = (fl && FLIP_EN) ? (N - 1 - t) : t;
        e.d = ram[(base + idx) % 256];
        e.l = (t == N - 1);
        tapq.push_back(e);
      end
  endtask

  task automatic run_job(input int base, input int rep, input bit fl,
                         input int mode, input bit chk_lat);
    int  k, first_v;
    bit  got_done;
    ready_mode = mode;
    expect_job(base, rep, fl);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); repeat_cnt = RCW'(rep); flip = fl;
    k = 0; first_v = -1; got_done = 1'b0;
    while (k < 3000 && !got_done) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (bus.fil_valid && first_v < 0) first_v = k;
      if (done) got_done = 1'b1;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (chk_lat) begin
      chk("done_latency", 32'(k), 32'(N + 2 + rep * N));
      chk("first_valid", 32'(first_v), (rep > 0) ? 32'(N + 2) : 32'hFFFF_FFFF);
    end
    @(posedge clk); #1;
    chk("done_pulse_len", 32'(done), 32'd0);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("taps_consumed", 32'(tapq.size()), 32'd0);
    chk("reads_done", 32'(addrq.size()), 32'd0);
    tapq.delete();
    addrq.delete();
    ready_mode = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(bus.fil_valid), 32'd0);
    chk({tag, "_out"}, 32'(bus.fil_out), 32'd0);
    chk({tag, "_last"}, 32'(bus.fil_last), 32'd0);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; repeat_cnt = '0; flip = 1'b0;
    foreach (ram[i]) ram[i] = DW'($urandom);
    for (int i = 0; i < N; i++) ram[16 + i] = DW'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    run_job(16, 2, 1'b0, 0, 1'b1);          // 1..9 twice, ready always
    run_job(16, 2, 1'b0, 1, 1'b0);          // same job, ready toggling
    run_job(16, 0, 1'b0, 0, 1'b1);          // zero repeats: load only
    run_job(254, 1, 1'b0, 0, 1'b1);         // address wrap FE,FF,00..06
    run_job(16, 1, 1'b1, 0, 1'b1);          // flip request

    // Reset in the middle of the stream, at tap 4 of the first pass.
    begin
      int k;
      ready_mode = 0;
      expect_job(16, 2, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h10; repeat_cnt = 16'd2; flip = 1'b0;
      k = 0;
      while (k < N + 6) begin
        @(posedge clk); #1;
        start = 1'b0;
        k++;
      end
      chk("pre_reset_tap", 32'(bus.fil_out), 32'd5);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      tapq.delete();
      addrq.delete();
      rst = 1'b1;
      run_job(16, 1, 1'b0, 0, 1'b1);
    end

    // Randomized jobs over random RAM contents and ready patterns.
    for (int j = 0; j < 8; j++) begin
      foreach (ram[i]) ram[i] = DW'($urandom);
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
